// File: rtl/arb_requester_if.sv
// Handshake bundle between a local unit, one arbiter request/grant pair and the shared bus.
// The master modport is the requester agent; the slave modport is everything around it.
interface arb_requester_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic                   in_push_valid;
  logic [DATA_WIDTH-1:0]  in_push_data;
  logic                   out_push_ready;
  logic                   out_request;
  logic                   in_grant;
  logic                   out_bus_valid;
  logic [DATA_WIDTH-1:0]  out_bus_data;
  logic                   in_bus_ready;
  logic [COUNT_WIDTH-1:0] out_fifo_count;
  logic                   out_timeout;

  modport master (
    input  in_push_valid, in_push_data, in_grant, in_bus_ready,
    output out_push_ready, out_request, out_bus_valid, out_bus_data,
           out_fifo_count, out_timeout
  );

  modport slave (
    output in_push_valid, in_push_data, in_grant, in_bus_ready,
    input  out_push_ready, out_request, out_bus_valid, out_bus_data,
           out_fifo_count, out_timeout
  );
endinterface

// File: rtl/arb_requester.sv
// Requester agent for one round-robin arbiter port: FIFO-buffered words, request/grant FSM, burst limit.
// Optional grant-starvation watchdog enabled by defining ARB_REQ_WATCHDOG_EN.
module arb_requester #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic           in_clk,
  input  logic           in_reset,
  arb_requester_if.master port
);
  localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int COUNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(FIFO_DEPTH);
  localparam logic [7:0]             BURST_LAST = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic [COUNT_WIDTH-1:0] count;
  logic [7:0]             burst_cnt;
  logic                   push_fire, pop_fire, bus_valid, request;

  // Full refuses a push even when a pop frees a slot in the same cycle.
  assign push_fire = port.in_push_valid && (count != FULL_COUNT);
  assign pop_fire  = bus_valid && port.in_bus_ready;

  always_ff @(posedge in_clk or posedge in_reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (in_reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_next;
      if (push_fire) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + COUNT_WIDTH'(1);
        2'b01:   count <= count - COUNT_WIDTH'(1);
        default: count <= count;
      endcase
      if (state == REQ && port.in_grant) burst_cnt <= '0;
      else if (pop_fire)                 burst_cnt <= burst_cnt + 8'd1;
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by the pointers and count, which are reset.
  always_ff @(posedge in_clk) begin
    if (push_fire) mem[wr_ptr] <= port.in_push_data;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next = state;
    request    = 1'b0;
    bus_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) state_next = REQ;
      end
      REQ: begin
        request = 1'b1;
        if (port.in_grant) state_next = XFER;
      end
      XFER: begin
        request   = 1'b1;
        bus_valid = port.in_grant && (count != '0);
        if (!port.in_grant) begin
          state_next = RELEASE;
        end else if (bus_valid && port.in_bus_ready &&
                     ((count == COUNT_WIDTH'(1) && !push_fire) || burst_cnt == BURST_LAST)) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign port.out_request    = request;
  assign port.out_bus_valid  = bus_valid;
  assign port.out_bus_data   = mem[rd_ptr];
  assign port.out_push_ready = (count != FULL_COUNT);
  assign port.out_fifo_count = count;

`ifdef ARB_REQ_WATCHDOG_EN
  logic [7:0] wd_cnt;
  logic       timeout_q;

  // Flag rises on the edge that completes the 255th ungranted REQ cycle.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (state == REQ && !port.in_grant) begin
      if (wd_cnt != 8'hFF) wd_cnt <= wd_cnt + 8'd1;
      if (wd_cnt == 8'hFE) timeout_q <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign port.out_timeout = timeout_q;
`else
  assign port.out_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: basic transfer, burst limit, revoke/stall, full FIFO, reset, watchdog.
// Expected values are hand-derived cycle by cycle from the block's documented behaviour.
module tb_arb_requester;
  logic in_clk;
  logic in_reset;
  int   n_vec;
  int   n_err;

  arb_requester_if #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) bus_if ();

  arb_requester #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .MAX_BURST(8)) dut (
    .in_clk   (in_clk),
    .in_reset (in_reset),
    .port     (bus_if)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [31:0] data, input logic grant, input logic ready);
    bus_if.in_push_valid = pv;
    bus_if.in_push_data  = data;
    bus_if.in_grant      = grant;
    bus_if.in_bus_ready  = ready;
    #1;
  endtask

  initial begin
    int popped, run, nb, pushed, low, gap;
    int bursts [4];
    logic prev_req, pv;
    logic exp_to_before, exp_to_after;

    n_vec = 0;
    n_err = 0;
    in_clk = 1'b0;
    in_reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1);

    // Reset values
    check("rst_request", bus_if.out_request, 0);
    check("rst_bus_valid", bus_if.out_bus_valid, 0);
    check("rst_push_ready", bus_if.out_push_ready, 1);
    check("rst_count", bus_if.out_fifo_count, 0);
    check("rst_timeout", bus_if.out_timeout, 0);
    step();
    step();
    in_reset = 1'b0;

    // Basic transfer: three words, grant and ready held high
    drive(1'b1, 32'hA1, 1'b1, 1'b1);
    check("t1_count0", bus_if.out_fifo_count, 0);
    step();
    drive(1'b1, 32'hA2, 1'b1, 1'b1);
    check("t1_req_lat0", bus_if.out_request, 0);
    check("t1_count1", bus_if.out_fifo_count, 1);
    step();
    drive(1'b1, 32'hA3, 1'b1, 1'b1);
    check("t1_req_lat1", bus_if.out_request, 1);
    check("t1_req_novalid", bus_if.out_bus_valid, 0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("t1_valid0", bus_if.out_bus_valid, 1);
    check("t1_data0", bus_if.out_bus_data, 32'hA1);
    check("t1_count3", bus_if.out_fifo_count, 3);
    step();
    check("t1_data1", bus_if.out_bus_data, 32'hA2);
    check("t1_valid1", bus_if.out_bus_valid, 1);
    step();
    check("t1_data2", bus_if.out_bus_data, 32'hA3);
    check("t1_valid2", bus_if.out_bus_valid, 1);
    step();
    check("t1_release_req", bus_if.out_request, 0);
    check("t1_release_count", bus_if.out_fifo_count, 0);
    step();
    check("t1_idle_req", bus_if.out_request, 0);
    check("t1_idle_valid", bus_if.out_bus_valid, 0);
    step();
    check("t1_idle_stays", bus_if.out_request, 0);

    // Burst limit: twelve words streamed through a 4-deep FIFO, grant held high
    popped = 0; run = 0; nb = 0; pushed = 0; low = 0; gap = -1;
    prev_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      pv = (pushed < 12);
      drive(pv, 32'hB0 + 32'(pushed), 1'b1, 1'b1);
      if (bus_if.out_bus_valid) begin
        check("t2_order", bus_if.out_bus_data, 64'(32'hB0 + 32'(popped)));
        popped++;
        run++;
      end
      if (prev_req && !bus_if.out_request) begin
        if (nb < 4) bursts[nb] = run;
        nb++;
        run = 0;
        low = 0;
      end
      if (!bus_if.out_request) low++;
      if (!prev_req && bus_if.out_request && nb == 1) gap = low;
      if (pv && bus_if.out_push_ready) pushed++;
      prev_req = bus_if.out_request;
      step();
    end
    check("t2_num_grants", nb, 2);
    check("t2_burst0", bursts[0], 8);
    check("t2_burst1", bursts[1], 4);
    check("t2_popped", popped, 12);
    check("t2_low_gap", gap, 2);
    check("t2_end_count", bus_if.out_fifo_count, 0);

    // Full FIFO, grant revoke and stall
    drive(1'b1, 32'hC0, 1'b0, 1'b1); step();
    drive(1'b1, 32'hC1, 1'b0, 1'b1); step();
    drive(1'b1, 32'hC2, 1'b0, 1'b1); step();
    drive(1'b1, 32'hC3, 1'b0, 1'b1);
    check("t3_ready_before_full", bus_if.out_push_ready, 1);
    step();
    drive(1'b1, 32'hC4, 1'b0, 1'b1);
    check("t3_full_ready", bus_if.out_push_ready, 0);
    check("t3_full_count", bus_if.out_fifo_count, 4);
    check("t3_req_nograt", bus_if.out_request, 1);
    step();
    drive(1'b1, 32'hC4, 1'b1, 1'b1);
    check("t3_req_novalid", bus_if.out_bus_valid, 0);
    check("t3_refused", bus_if.out_fifo_count, 4);
    step();
    check("t3_xfer_valid", bus_if.out_bus_valid, 1);
    check("t3_xfer_data0", bus_if.out_bus_data, 32'hC0);
    check("t3_ready_with_pop", bus_if.out_push_ready, 0);
    step();
    check("t3_pop_refuse_count", bus_if.out_fifo_count, 3);
    check("t3_xfer_data1", bus_if.out_bus_data, 32'hC1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t3_revoke_valid", bus_if.out_bus_valid, 0);
    check("t3_revoke_req", bus_if.out_request, 1);
    check("t3_revoke_count", bus_if.out_fifo_count, 3);
    step();
    check("t3_release_req", bus_if.out_request, 0);
    check("t3_release_count", bus_if.out_fifo_count, 3);
    step();
    check("t3_idle_req", bus_if.out_request, 0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("t3_rereq", bus_if.out_request, 1);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("t3_resend_valid", bus_if.out_bus_valid, 1);
    check("t3_resend_data", bus_if.out_bus_data, 32'hC2);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("t3_stall_valid", bus_if.out_bus_valid, 1);
    check("t3_stall_data", bus_if.out_bus_data, 32'hC2);
    check("t3_stall_count", bus_if.out_fifo_count, 3);
    step();
    check("t3_data_c3", bus_if.out_bus_data, 32'hC3);
    step();
    check("t3_data_c4", bus_if.out_bus_data, 32'hC4);
    step();
    check("t3_end_count", bus_if.out_fifo_count, 0);
    check("t3_end_req", bus_if.out_request, 0);
    step();

    // Reset mid-burst: asynchronous, between clock edges
    drive(1'b1, 32'hD0, 1'b1, 1'b1); step();
    drive(1'b1, 32'hD1, 1'b1, 1'b1); step();
    drive(1'b0, 32'h0, 1'b1, 1'b1); step();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("t4_in_xfer", bus_if.out_bus_valid, 1);
    #2;
    in_reset = 1'b1;
    #1;
    check("t4_async_req", bus_if.out_request, 0);
    check("t4_async_valid", bus_if.out_bus_valid, 0);
    check("t4_async_count", bus_if.out_fifo_count, 0);
    #1;
    in_reset = 1'b0;
    step();
    check("t4_post_req0", bus_if.out_request, 0);
    step();
    check("t4_post_req1", bus_if.out_request, 0);
    check("t4_post_count", bus_if.out_fifo_count, 0);

    // Watchdog: one word, grant withheld for 300 cycles
`ifdef ARB_REQ_WATCHDOG_EN
    exp_to_before = 1'b0;
    exp_to_after  = 1'b1;
`else
    exp_to_before = 1'b0;
    exp_to_after  = 1'b0;
`endif
    drive(1'b1, 32'hE0, 1'b0, 1'b1); step();
    drive(1'b0, 32'h0, 1'b0, 1'b1); step();
    check("t5_in_req", bus_if.out_request, 1);
    for (int i = 0; i < 254; i++) step();
    check("t5_timeout_254", bus_if.out_timeout, 64'(exp_to_before));
    step();
    check("t5_timeout_255", bus_if.out_timeout, 64'(exp_to_after));
    for (int i = 0; i < 45; i++) step();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    step();
    check("t5_late_valid", bus_if.out_bus_valid, 1);
    check("t5_late_data", bus_if.out_bus_data, 32'hE0);
    step();
    step();
    check("t5_timeout_sticky", bus_if.out_timeout, 64'(exp_to_after));
    check("t5_end_count", bus_if.out_fifo_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
